// File: rtl/mips_seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// mips_div_pkg : shared types and constants for the sequential MIPS divider
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH + 1;

endpackage

`default_nettype wire

// File: rtl/mips_seq_divider_if.sv
// ---------------------------------------------------------------------------
// mips_seq_divider_if : request/result bundle between EX stage and divider
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mips_seq_divider_if
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/mips_seq_divider_trial_sub.sv
// ---------------------------------------------------------------------------
// div_trial_sub : (WIDTH+1)-bit subtractor, a + ~b + 1, with borrow out
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_trial_sub
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic [WIDTH:0] a,
    input  wire logic [WIDTH:0] b,
    output logic      [WIDTH:0] diff,
    output logic                borrow
);
    logic [WIDTH+1:0] w_sum;

    // Carry out of the extra top bit is set exactly when a >= b.
    assign w_sum  = {1'b0, a} + {1'b0, ~b} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign diff   = w_sum[WIDTH:0];
    assign borrow = ~w_sum[WIDTH+1];
endmodule

`default_nettype wire

// File: rtl/mips_seq_divider.sv
// ---------------------------------------------------------------------------
// mips_seq_divider : restoring DIV/DIVU divider, one quotient bit per clock
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_seq_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mips_seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd_sh;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dvd_raw;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_keep;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;

    assign w_dvd_abs = (bus.is_signed && bus.dividend[WIDTH-1]) ?
                       (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign w_dvs_abs = (bus.is_signed && bus.divisor[WIDTH-1]) ?
                       (~bus.divisor + WIDTH'(1)) : bus.divisor;

    assign w_shifted = {r_rem, r_dvd_sh[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .a      (w_shifted),
        .b      ({1'b0, r_dvs}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    // A non-negative trial leaves the (WIDTH+1)-bit sign clear as well.
    assign w_keep     = !w_borrow && !w_diff[WIDTH];
    assign w_rem_next = w_keep ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_quo_next = {r_dvd_sh[WIDTH-2:0], w_keep};

    assign w_q_fix = r_q_neg ? (~w_quo_next + WIDTH'(1)) : w_quo_next;
    assign w_r_fix = r_r_neg ? (~w_rem_next + WIDTH'(1)) : w_rem_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_rem           <= '0;
            r_dvd_sh        <= '0;
            r_dvs           <= '0;
            r_dvd_raw       <= '0;
            r_q_neg         <= 1'b0;
            r_r_neg         <= 1'b0;
            r_dz            <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dvd_sh  <= w_dvd_abs;
                        r_dvs     <= w_dvs_abs;
                        r_dvd_raw <= bus.dividend;
                        r_q_neg   <= bus.is_signed &
                                     (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_r_neg   <= bus.is_signed & bus.dividend[WIDTH-1];
                        r_dz      <= (bus.divisor == '0);
                        r_rem     <= '0;
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_state   <= CALC;
                        bus.busy  <= 1'b1;
                    end
                end
                CALC: begin
                    r_rem    <= w_rem_next;
                    r_dvd_sh <= w_quo_next;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state         <= DONE;
                        bus.done        <= 1'b1;
                        bus.quotient    <= r_dz ? '1 : w_q_fix;
                        bus.remainder   <= r_dz ? r_dvd_raw : w_r_fix;
                        bus.div_by_zero <= r_dz;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire
